// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped byte cache.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StWmem,
        StResp
    } state_e;

    localparam int unsigned OFFSET_W    = 3;
    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned MAX_ADDR_W  = 64;

    // Callers zero-extend the address to MAX_ADDR_W and truncate the result to their field width.
    function automatic logic [MAX_ADDR_W-1:0] line_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned idx_w);
        return (addr >> OFFSET_W) & ((MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1));
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] line_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache; only the valid bits are reset.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned TAG_W = 27
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    output logic                hit,
    output logic [63:0]         rd_block,
    input  logic                fill_en,
    input  logic [63:0]         fill_block,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [7:0]          wr_byte
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [63:0]      data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[rd_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[rd_index]  <= rd_tag;
            data_mem[rd_index] <= fill_block;
        end else if (wr_en) begin
            data_mem[rd_index][{wr_offset, 3'b000} +: 8] <= wr_byte;
        end
    end

    assign hit      = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_block = data_mem[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache in front of the RAM block,
// with saturating read hit/miss counters.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned LINES     = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic              we_q, we_d, err_q, err_d;
    logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] offset;
    logic                in_range, hit, fill_en, wr_en;
    logic [63:0]         rd_block;

    assign idx      = IDX_W'(line_index(MAX_ADDR_W'(addr_q), IDX_W));
    assign tag      = TAG_W'(line_tag(MAX_ADDR_W'(addr_q), IDX_W));
    assign offset   = addr_q[OFFSET_W-1:0];
    assign in_range = addr_q < ADDR_W'(MEM_BYTES);
    assign fill_en  = (state_q == StFill) && mem_done;
    assign wr_en    = (state_q == StLookup) && in_range && we_q && hit;

    cache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (idx),
        .rd_tag     (tag),
        .hit        (hit),
        .rd_block   (rd_block),
        .fill_en    (fill_en),
        .fill_block (mem_rdata),
        .wr_en      (wr_en),
        .wr_offset  (offset),
        .wr_byte    (wdata_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_req) state_d = StLookup;
            StLookup: begin
                if (!in_range)  state_d = StResp;
                else if (we_q)  state_d = StWmem;
                else if (hit)   state_d = StResp;
                else            state_d = StFill;
            end
            StFill:   if (mem_done) state_d = StResp;
            StWmem:   if (mem_done) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                end
            end
            StLookup: begin
                err_d = !in_range;
                if (in_range) begin
                    if (we_q) begin
                        mem_addr_d  = addr_q;
                        mem_wdata_d = wdata_q;
                    end else if (hit) begin
                        rdata_d = rd_block[{offset, 3'b000} +: 8];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            StFill: begin
                if (mem_done) rdata_d = mem_rdata[{offset, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Handshake outputs decode the registered state, so reset drops mem_req at once.
    always_comb begin
        cpu_ready = (state_q == StResp);
        cpu_err   = (state_q == StResp) && err_q;
        mem_req   = (state_q == StFill) || (state_q == StWmem);
        mem_we    = (state_q == StWmem);
    end

    assign cpu_rdata  = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate byte cache that sits directly upstream of the RAM block. It accepts byte read/write requests from the CPU side and serves read hits locally. On a read miss it fetches the aligned 64-bit block from RAM through the hit_miss/r_w/access_done handshake; every write is forwarded to RAM. It also keeps saturating hit/miss statistics for the memory-subsystem testbench.

Parameters:
LINES, 4, number of cache lines (power of 2, >=2)
ADDR_W, 32, address width
MEM_BYTES, 128, size of backing RAM in bytes; addresses >= MEM_BYTES are errors
CNT_W, 16, width of hit/miss counters

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  reset, asynchronous, active-low
cpu_req  input  1  request strobe, sampled only in IDLE
cpu_we  input  1  0 = read, 1 = write
cpu_addr  input  ADDR_W  byte address
cpu_wdata  input  8  write byte
cpu_rdata  output  8  read byte, valid when cpu_ready=1 and cpu_we was 0
cpu_ready  output  1  one-cycle completion pulse
cpu_err  output  1  asserted with cpu_ready when the address is out of range
mem_req  output  1  to RAM hit_miss; 1 = RAM access in progress
mem_we  output  1  to RAM r_w; 0 = read, 1 = write
mem_addr  output  ADDR_W  to RAM address
mem_wdata  output  8  byte to write into RAM
mem_rdata  input  64  block from RAM, byte k = bits [8k+7:8k]
mem_done  input  1  RAM access_done
hit_count  output  CNT_W  saturating count of read hits
miss_count  output  CNT_W  saturating count of read misses

Behaviour:
- Address split: offset = addr[2:0]; index = addr[2+log2(LINES):3]; tag = remaining upper bits.
- Storage: per line, valid bit, tag, and a 64-bit data block.
- Reset (async, low): state = IDLE. All valid bits = 0. cpu_ready, cpu_err, mem_req, mem_we = 0. cpu_rdata, mem_addr, mem_wdata = 0. Both counters = 0. Reset mid-fill or mid-write abandons the access; mem_req drops immediately, and no line is written.
- FSM states: IDLE, LOOKUP, FILL, WMEM, RESP.
- IDLE:
  - If cpu_req=1, latch addr, we and wdata, then go to LOOKUP. cpu_req is ignored in all other states.
- LOOKUP (one cycle):
  - If addr >= MEM_BYTES: go to RESP with err=1. No RAM access, no counter change.
  - Read hit: cpu_rdata = byte[offset] of the line; hit_count += 1; go to RESP.
  - Read miss: miss_count += 1; go to FILL.
  - Write: if hit, update byte[offset] in the line. A write miss does not allocate. Go to WMEM.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {addr[ADDR_W-1:3],3'b000}.
  - On the posedge where mem_done=1: write mem_rdata into the line, set valid, set tag, set cpu_rdata = mem_rdata byte[offset], then go to RESP.
- WMEM:
  - mem_req=1, mem_we=1, mem_addr = the full latched addr, mem_wdata = wdata.
  - On mem_done=1, go to RESP.
- RESP:
  - cpu_ready=1 for exactly one cycle; cpu_err is valid in the same cycle.
  - mem_req=0; mem_addr holds its value.
  - Next state is IDLE.
- mem_req deasserts in the cycle after mem_done is sampled, so the RAM sees hit_miss fall before it could start another access.
- Timing is measured from the cycle in which IDLE samples cpu_req:
  - Read hit: cpu_ready asserts 2 cycles later.
  - Miss or write: cpu_ready asserts 1 cycle after mem_done is sampled.
- mem_done arriving outside FILL/WMEM is ignored.
- Counters saturate at all-ones.
- Outputs are registered; cpu_rdata holds its value until the next read completes.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, LOOKUP, FILL, WMEM, RESP)
  - OFFSET_W = 3, BLOCK_BYTES = 8
  - functions for index and tag extraction
- Sub-module cache_line_array:
  - holds the valid/tag/data arrays, with async clear of valid
  - ports: read by index, hit compare, full-block fill, byte write
- The FSM and counters stay in dm_cache_ctrl.

Test Plan:
All cases use a RAM preloaded with ram[i] = i.
1. Read 0x05 after reset -> FILL with mem_addr=0x00 -> cpu_rdata=0x05; miss_count=1; cpu_ready exactly 1 cycle after mem_done.
2. Read 0x03 immediately after case 1 -> hit; cpu_ready 2 cycles after the request; cpu_rdata=0x03; hit_count=1; mem_req stays 0.
3. Write 0x05=0xAA, then read 0x05 -> WMEM with mem_addr=0x05 and mem_wdata=0xAA; the read then hits and returns 0xAA.
4. Conflict: read 0x25 (index 0, tag differs) -> miss and refill from 0x20; cpu_rdata=0x25. A following read of 0x05 misses again; miss_count=3.
5. Read 0x80 -> cpu_ready with cpu_err=1 on the 2nd cycle; mem_req never asserts; counters unchanged.
6. Assert reset 4 cycles into a FILL -> mem_req=0 immediately, state IDLE. A following read of 0x05 misses (line invalid).
